// File: rtl/btn_debounce_select.sv
// btn_debounce_select: debounces a raw button into a level, press/release/long-press pulses and a toggling digit select
module btn_debounce_select #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int CNT_W           = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic sel
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             s0_q, s1_q;
  logic             level_q, level_d, press_q, press_d, release_q, release_d;
  logic             long_q, long_d, long_done_q, long_done_d, sel_q, sel_d;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  // next-state: stability counting, one-shot pulses and the once-per-press long-press latch
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    long_done_d = long_done_q;
    sel_d       = sel_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s1_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s1_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == DB_LAST) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          level_d     = 1'b1;
          press_d     = 1'b1;
          sel_d       = ~sel_q;
          long_done_d = 1'b0;
        end
      end
      PRESSED: begin
        if (!s1_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST && !long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s1_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // synchroniser chain plus all FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      s0_q        <= btn_raw;
      s1_q        <= s0_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      long_done_q <= long_done_d;
      sel_q       <= sel_d;
    end
  end
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign sel           = sel_q;
endmodule

// File: tb/tb_btn_debounce_select.sv
// tb_btn_debounce_select: directed and random stimulus against a run-length reference model
module tb_btn_debounce_select;
  localparam int DEB = 8;
  localparam int LNG = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_press, sel;
  int vectors = 0;
  int miscompares = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int n, p0, r0, l0;
  logic m_s0, m_s1, m_level, m_done, m_sel, e_press, e_rel, e_long;
  int m_run, m_h;

  btn_debounce_select #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press(long_press), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: level flips after DEB consecutive sampled edges disagreeing with it;
  // long fires on the LNG-th consecutive high edge after acceptance or after a bounce back
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s0 = 0; m_s1 = 0; m_level = 0; m_done = 0; m_sel = 0;
      e_press = 0; e_rel = 0; e_long = 0; m_run = 0; m_h = -1;
    end else begin
      e_press = 0; e_rel = 0; e_long = 0;
      if (m_s1 != m_level) m_run++; else m_run = 0;
      if (m_level) begin
        if (!m_s1) m_h = -1;
        else begin
          m_h = (m_h < 0) ? 0 : m_h + 1;
          if (m_h == LNG && !m_done) begin e_long = 1; m_done = 1; end
        end
      end
      if (m_run == DEB) begin
        m_run = 0;
        m_level = !m_level;
        if (m_level) begin e_press = 1; m_sel = !m_sel; m_h = 0; m_done = 0; end
        else e_rel = 1;
      end
      m_s1 = m_s0;
      m_s0 = btn_raw;
    end
  end

  always @(negedge clk) begin
    chk("level", btn_level, m_level);
    chk("press", press_pulse, e_press);
    chk("release", release_pulse, e_rel);
    chk("long", long_press, e_long);
    chk("sel", sel, m_sel);
    n_press += press_pulse;
    n_rel += release_pulse;
    n_long += long_press;
  end

  function automatic logic pick(input int which);
    return which == 0 ? press_pulse : which == 1 ? release_pulse : long_press;
  endfunction

  task automatic wait_for(input int which, input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!pick(which) && cnt < budget);
  endtask

  task automatic hold(input logic v, input int cyc);
    btn_raw = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", {btn_level, press_pulse, release_pulse, long_press, sel}, 0);
    rst = 1'b0;
    btn_raw = 1'b1;
    wait_for(0, 30, n);
    chk("t1_lat", n, 10);
    @(negedge clk);
    chk("t1_level", btn_level, 1);
    chk("t1_sel", sel, 1);
    hold(0, 20);
    do_reset();
    p0 = n_press;
    hold(1, 1); hold(0, 2); hold(1, 3); hold(0, 2); hold(1, 7); hold(0, 15);
    chk("t2_press", n_press - p0, 0);
    chk("t2_level", btn_level, 0);
    chk("t2_sel", sel, 0);
    do_reset();
    hold(1, 15);
    r0 = n_rel;
    hold(0, 3); hold(1, 2);
    btn_raw = 1'b0;
    wait_for(1, 30, n);
    chk("t3_lat", n, 10);
    hold(0, 5);
    chk("t3_rel_cnt", n_rel - r0, 1);
    chk("t3_level", btn_level, 0);
    do_reset();
    btn_raw = 1'b1;
    wait_for(0, 30, n);
    l0 = n_long;
    wait_for(2, 60, n);
    chk("t4_lat", n, 32);
    hold(1, 50);
    chk("t4_once", n_long - l0, 1);
    hold(0, 20);
    do_reset();
    p0 = n_press; r0 = n_rel; l0 = n_long;
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'b1;
      wait_for(0, 30, n);
      chk("t5_sel", sel, (i % 2 == 0) ? 1 : 0);
      hold(1, 5);
      hold(0, 20);
    end
    chk("t5_press", n_press - p0, 3);
    chk("t5_rel", n_rel - r0, 3);
    chk("t5_long", n_long - l0, 0);
    do_reset();
    btn_raw = 1'b1;
    wait_for(0, 30, n);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("t6_async", {btn_level, press_pulse, release_pulse, long_press, sel}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_for(0, 30, n);
    chk("t6_lat", n, 10);
    do_reset();
    repeat (300) begin
      hold(~btn_raw, $urandom_range(1, 45));
      if ($urandom_range(0, 39) == 0) begin
        #3 rst = 1'b1;
        #4 rst = 1'b0;
        @(negedge clk);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
